// File: rtl/gpio_debounce.sv
// Per-bit synchroniser and debounce filter for raw board pins.
// Produces clean clk-synchronous levels plus one-cycle rise/fall pulses.
module gpio_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;
  logic [WIDTH-1:0]                  r_dout;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;
  logic [CNT_W-1:0]                  r_cnt   [WIDTH];
  state_t                            r_state [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{{WIDTH{RESET_VAL}}}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // cnt counts cycles s has differed from dout; commit when it reaches the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= {WIDTH{RESET_VAL}};
      r_rise <= '0;
      r_fall <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i]   <= '0;
        r_state[i] <= ST_STABLE;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        unique case (r_state[i])
          ST_STABLE: begin
            if (w_s[i] == r_dout[i]) begin
              r_cnt[i] <= '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
              r_dout[i] <= w_s[i];
              r_rise[i] <= w_s[i];
              r_fall[i] <= ~w_s[i];
              r_cnt[i]  <= '0;
            end else begin
              r_state[i] <= ST_PENDING;
              r_cnt[i]   <= CNT_W'(1);
            end
          end
          ST_PENDING: begin
            if (w_s[i] == r_dout[i]) begin
              r_state[i] <= ST_STABLE;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
              r_dout[i]  <= w_s[i];
              r_rise[i]  <= w_s[i];
              r_fall[i]  <= ~w_s[i];
              r_state[i] <= ST_STABLE;
              r_cnt[i]   <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            r_state[i] <= ST_STABLE;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: stimulus pushes expected commit events into queues,
// negedge monitors pop and compare whenever a rise/fall pulse appears.
module tb_gpio_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din4, din1;
  logic [1:0] dout4, rise4, fall4;
  logic [1:0] dout1, rise1, fall1;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
  } ev_t;

  ev_t q4[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_debounce #(
    .WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3), .RESET_VAL(1'b0)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .dout(dout4), .rise(rise4), .fall(fall4)
  );

  gpio_debounce #(
    .WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(1), .RESET_VAL(1'b0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .dout(dout1), .rise(rise1), .fall(fall1)
  );

  always @(negedge clk) begin
    ev_t e;
    if ((rise4 | fall4) != 2'b00) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_errors++;
        $display("FAIL dc4_unexpected_event: cycle %0d dout=%b rise=%b fall=%b, required no event",
                 cyc, dout4, rise4, fall4);
      end else begin
        e = q4.pop_front();
        if (e.cyc != cyc || e.dout != dout4 || e.rise != rise4 || e.fall != fall4) begin
          n_errors++;
          $display("FAIL dc4_event: got cycle %0d dout=%b rise=%b fall=%b, required cycle %0d dout=%b rise=%b fall=%b",
                   cyc, dout4, rise4, fall4, e.cyc, e.dout, e.rise, e.fall);
        end
      end
    end
    if ((rise1 | fall1) != 2'b00) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL dc1_unexpected_event: cycle %0d dout=%b rise=%b fall=%b, required no event",
                 cyc, dout1, rise1, fall1);
      end else begin
        e = q1.pop_front();
        if (e.cyc != cyc || e.dout != dout1 || e.rise != rise1 || e.fall != fall1) begin
          n_errors++;
          $display("FAIL dc1_event: got cycle %0d dout=%b rise=%b fall=%b, required cycle %0d dout=%b rise=%b fall=%b",
                   cyc, dout1, rise1, fall1, e.cyc, e.dout, e.rise, e.fall);
        end
      end
    end
  end

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive din4 at a negedge: the commit lands 6 edges later with DEBOUNCE_CYCLES=4.
  task automatic step4(input logic [1:0] d, input logic [1:0] nd,
                       input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    din4   = d;
    e.cyc  = cyc + 6;
    e.dout = nd;
    e.rise = r;
    e.fall = f;
    q4.push_back(e);
  endtask

  task automatic step1(input logic [1:0] d, input logic [1:0] nd,
                       input logic [1:0] r, input logic [1:0] f);
    ev_t e;
    din1   = d;
    e.cyc  = cyc + 3;
    e.dout = nd;
    e.rise = r;
    e.fall = f;
    q1.push_back(e);
  endtask

  initial begin
    ev_t e;
    rst_n = 1'b1;
    din4  = 2'b11;
    din1  = 2'b00;
    #1 rst_n = 1'b0;

    // Reset held with din=11: outputs stay cleared.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("reset_hold", {dout4, rise4, fall4}, 6'b00_00_00);
    end
    rst_n  = 1'b1;
    e.cyc  = cyc + 6;
    e.dout = 2'b11;
    e.rise = 2'b11;
    e.fall = 2'b00;
    q4.push_back(e);
    wait_cycles(10);
    check("post_reset_level", {dout4, rise4, fall4}, 6'b11_00_00);
    step4(2'b00, 2'b00, 2'b00, 2'b11);
    wait_cycles(10);

    // Clean step up and down on bit 0.
    step4(2'b01, 2'b01, 2'b01, 2'b00);
    wait_cycles(10);
    step4(2'b00, 2'b00, 2'b00, 2'b01);
    wait_cycles(10);

    // Bounce on bit 0, then settle high.
    din4 = 2'b01; wait_cycles(2);
    din4 = 2'b00; wait_cycles(2);
    din4 = 2'b01; wait_cycles(2);
    din4 = 2'b00; wait_cycles(2);
    step4(2'b01, 2'b01, 2'b01, 2'b00);
    wait_cycles(10);
    step4(2'b00, 2'b00, 2'b00, 2'b01);
    wait_cycles(10);

    // Three-cycle glitch on bit 1 must be rejected.
    din4 = 2'b10; wait_cycles(3);
    din4 = 2'b00; wait_cycles(10);
    check("glitch_rejected", {dout4, rise4, fall4}, 6'b00_00_00);

    // Async reset while bit 0 is mid-count; bit 1 already committed high.
    step4(2'b10, 2'b10, 2'b10, 2'b00);
    wait_cycles(10);
    din4 = 2'b11;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", {dout4, rise4, fall4}, 6'b00_00_00);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    e.cyc  = cyc + 6;
    e.dout = 2'b11;
    e.rise = 2'b11;
    e.fall = 2'b00;
    q4.push_back(e);
    wait_cycles(10);
    step4(2'b00, 2'b00, 2'b00, 2'b11);
    wait_cycles(10);

    // Simultaneous rise on both bits, then the single-cycle debounce instance.
    step4(2'b11, 2'b11, 2'b11, 2'b00);
    wait_cycles(10);
    check("simultaneous_level", {dout4, rise4, fall4}, 6'b11_00_00);
    step1(2'b11, 2'b11, 2'b11, 2'b00);
    wait_cycles(5);
    step1(2'b01, 2'b01, 2'b00, 2'b10);
    wait_cycles(5);
    check("dc1_level", {dout1, rise1, fall1}, 6'b01_00_00);

    n_checks++;
    if (q4.size() != 0) begin
      n_errors++;
      $display("FAIL dc4_missing_events: %0d pending, required 0", q4.size());
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_errors++;
      $display("FAIL dc1_missing_events: %0d pending, required 0", q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
